// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back select and misalign detection.
// Optional retire counter enabled by defining MEM_WB_RETIRE_CNT_EN.
module mem_wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            EX_MEM_valid,
  input  logic            EX_MEM_RegWrite,
  input  logic            EX_MEM_MemRead,
  input  logic            EX_MEM_MemWrite,
  input  logic [1:0]      EX_MEM_MemtoReg,
  input  logic [2:0]      EX_MEM_funct3,
  input  logic [4:0]      EX_MEM_rd,
  input  logic [XLEN-1:0] EX_MEM_ALU_result,
  input  logic [XLEN-1:0] EX_MEM_PC_plus4,
  input  logic [XLEN-1:0] ReadData,
  input  logic            stall,
  input  logic            flush,
  input  logic            exc_clr,
  output logic            MEM_WB_valid,
  output logic            MEM_WB_RegWrite,
  output logic [4:0]      MEM_WB_rd,
  output logic [XLEN-1:0] MEM_WB_WriteData,
  output logic            misalign_exc,
  output logic [XLEN-1:0] misalign_addr,
  output logic [CNT_W-1:0] retire_cnt
);

  logic            capture;
  logic            mem_acc;
  logic            bad_f3;
  logic            mis;
  logic            wb_we;
  logic [XLEN-1:0] wb_data;

  assign capture = !flush && !stall;

  // Misalign detection on the effective address, plus illegal load sizes
  always_comb begin
    mem_acc = EX_MEM_valid && (EX_MEM_MemRead || EX_MEM_MemWrite);
    bad_f3  = EX_MEM_MemRead &&
              ((EX_MEM_funct3 == 3'b011) ||
               (EX_MEM_funct3 == 3'b110) ||
               (EX_MEM_funct3 == 3'b111));
    mis     = 1'b0;
    unique case (1'b1)
      (EX_MEM_funct3[1:0] == 2'b01):
        mis = EX_MEM_ALU_result[0];
      (EX_MEM_funct3[1:0] == 2'b10):
        mis = (EX_MEM_ALU_result[1:0] != 2'b00);
      default:
        mis = 1'b0;
    endcase
    mis = mem_acc && (mis || bad_f3);
  end

  // Write-back data select and qualified write enable
  always_comb begin
    wb_data = '0;
    unique case (EX_MEM_MemtoReg)
      2'b00:   wb_data = EX_MEM_ALU_result;
      2'b01:   wb_data = ReadData;
      2'b10:   wb_data = EX_MEM_PC_plus4;
      default: wb_data = '0;
    endcase
    wb_we = EX_MEM_valid && EX_MEM_RegWrite &&
            (EX_MEM_rd != 5'd0) && !mis &&
            (EX_MEM_MemtoReg != 2'b11) &&
            !EX_MEM_MemWrite;
  end

  // Pipeline register: flush beats stall beats capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MEM_WB_valid     <= 1'b0;
      MEM_WB_RegWrite  <= 1'b0;
      MEM_WB_rd        <= '0;
      MEM_WB_WriteData <= '0;
    end else if (flush) begin
      MEM_WB_valid     <= 1'b0;
      MEM_WB_RegWrite  <= 1'b0;
      MEM_WB_rd        <= '0;
      MEM_WB_WriteData <= '0;
    end else if (!stall) begin
      MEM_WB_valid     <= EX_MEM_valid;
      MEM_WB_RegWrite  <= wb_we;
      MEM_WB_rd        <= EX_MEM_rd;
      MEM_WB_WriteData <= wb_data;
    end
  end

  // Sticky misalign flag; first address kept, new set beats clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_exc  <= 1'b0;
      misalign_addr <= '0;
    end else if (capture && mis) begin
      misalign_exc <= 1'b1;
      if (!misalign_exc || exc_clr)
        misalign_addr <= EX_MEM_ALU_result;
    end else if (exc_clr) begin
      misalign_exc  <= 1'b0;
      misalign_addr <= '0;
    end
  end

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Count every valid instruction entering WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (capture && EX_MEM_valid)
      cnt_q <= cnt_q + 1'b1;
  end

  assign retire_cnt = cnt_q;
`else
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage.
// Counter checks compile in when MEM_WB_RETIRE_CNT_EN is defined.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        v, rw, mr, mw;
  logic [1:0]  m2r;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [31:0] alu, pc4, rdat;
  logic        stall, flush, exc_clr;
  logic        o_v, o_rw, o_exc;
  logic [4:0]  o_rd;
  logic [31:0] o_wd, o_addr, o_cnt;

  int checks = 0;
  int errors = 0;

  mem_wb_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .EX_MEM_valid(v), .EX_MEM_RegWrite(rw),
    .EX_MEM_MemRead(mr), .EX_MEM_MemWrite(mw),
    .EX_MEM_MemtoReg(m2r), .EX_MEM_funct3(f3),
    .EX_MEM_rd(rd), .EX_MEM_ALU_result(alu),
    .EX_MEM_PC_plus4(pc4), .ReadData(rdat),
    .stall(stall), .flush(flush), .exc_clr(exc_clr),
    .MEM_WB_valid(o_v), .MEM_WB_RegWrite(o_rw),
    .MEM_WB_rd(o_rd), .MEM_WB_WriteData(o_wd),
    .misalign_exc(o_exc), .misalign_addr(o_addr),
    .retire_cnt(o_cnt)
  );

`ifdef MEM_WB_RETIRE_CNT_EN
  logic        s_v, s_rw, s_exc;
  logic [4:0]  s_rd;
  logic [31:0] s_wd, s_addr;
  logic [3:0]  s_cnt;

  mem_wb_stage #(.XLEN(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .EX_MEM_valid(v), .EX_MEM_RegWrite(rw),
    .EX_MEM_MemRead(mr), .EX_MEM_MemWrite(mw),
    .EX_MEM_MemtoReg(m2r), .EX_MEM_funct3(f3),
    .EX_MEM_rd(rd), .EX_MEM_ALU_result(alu),
    .EX_MEM_PC_plus4(pc4), .ReadData(rdat),
    .stall(stall), .flush(flush), .exc_clr(exc_clr),
    .MEM_WB_valid(s_v), .MEM_WB_RegWrite(s_rw),
    .MEM_WB_rd(s_rd), .MEM_WB_WriteData(s_wd),
    .misalign_exc(s_exc), .misalign_addr(s_addr),
    .retire_cnt(s_cnt)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    v = 0; rw = 0; mr = 0; mw = 0; m2r = 2'b00; f3 = 3'b000;
    rd = 0; alu = 0; pc4 = 0; rdat = 0;
    stall = 0; flush = 0; exc_clr = 0;
  endtask

  task automatic vec(input logic iv, input logic irw,
                     input logic imr, input logic imw,
                     input logic [1:0] im2r, input logic [2:0] if3,
                     input logic [4:0] ird, input logic [31:0] ialu,
                     input logic [31:0] ipc4, input logic [31:0] irdat);
    idle();
    v = iv; rw = irw; mr = imr; mw = imw; m2r = im2r; f3 = if3;
    rd = ird; alu = ialu; pc4 = ipc4; rdat = irdat;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    repeat (2) cycle();
    checks++; if (o_v !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", o_v); end
    checks++; if (o_rw !== 1'b0) begin errors++; $display("FAIL rst_rw got %b want 0", o_rw); end
    checks++; if (o_rd !== 5'd0) begin errors++; $display("FAIL rst_rd got %0d want 0", o_rd); end
    checks++; if (o_wd !== 32'h0) begin errors++; $display("FAIL rst_wd got %h want 0", o_wd); end
    checks++; if (o_exc !== 1'b0) begin errors++; $display("FAIL rst_exc got %b want 0", o_exc); end
    checks++; if (o_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", o_addr); end
    checks++; if (o_cnt !== 32'h0) begin errors++; $display("FAIL rst_cnt got %0d want 0", o_cnt); end
    #2 rst_n = 1;
  endtask

  task automatic test_load();
    vec(1, 1, 1, 0, 2'b01, 3'b010, 5, 32'h10, 32'h0, 32'hDEADBEEF);
    cycle();
    checks++; if (o_v !== 1'b1) begin errors++; $display("FAIL lw_valid got %b want 1", o_v); end
    checks++; if (o_rw !== 1'b1) begin errors++; $display("FAIL lw_rw got %b want 1", o_rw); end
    checks++; if (o_rd !== 5'd5) begin errors++; $display("FAIL lw_rd got %0d want 5", o_rd); end
    checks++; if (o_wd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_wd got %h want deadbeef", o_wd); end
    checks++; if (o_exc !== 1'b0) begin errors++; $display("FAIL lw_exc got %b want 0", o_exc); end
  endtask

  task automatic test_alu_jal();
    vec(1, 1, 0, 0, 2'b00, 3'b000, 0, 32'h7, 32'h0, 32'h0);
    cycle();
    checks++; if (o_v !== 1'b1) begin errors++; $display("FAIL add_x0_valid got %b want 1", o_v); end
    checks++; if (o_rw !== 1'b0) begin errors++; $display("FAIL add_x0_rw got %b want 0", o_rw); end
    checks++; if (o_wd !== 32'h7) begin errors++; $display("FAIL add_x0_wd got %h want 7", o_wd); end
    vec(1, 1, 0, 0, 2'b10, 3'b000, 1, 32'h200, 32'h104, 32'h0);
    cycle();
    checks++; if (o_wd !== 32'h104) begin errors++; $display("FAIL jal_wd got %h want 104", o_wd); end
    checks++; if (o_rw !== 1'b1) begin errors++; $display("FAIL jal_rw got %b want 1", o_rw); end
    checks++; if (o_rd !== 5'd1) begin errors++; $display("FAIL jal_rd got %0d want 1", o_rd); end
    vec(1, 1, 0, 0, 2'b11, 3'b000, 2, 32'h33, 32'h44, 32'h55);
    cycle();
    checks++; if (o_rw !== 1'b0) begin errors++; $display("FAIL m2r11_rw got %b want 0", o_rw); end
    checks++; if (o_wd !== 32'h0) begin errors++; $display("FAIL m2r11_wd got %h want 0", o_wd); end
    vec(1, 1, 0, 1, 2'b00, 3'b010, 4, 32'h8, 32'h0, 32'h0);
    cycle();
    checks++; if (o_rw !== 1'b0) begin errors++; $display("FAIL sw_rw got %b want 0", o_rw); end
    checks++; if (o_v !== 1'b1) begin errors++; $display("FAIL sw_valid got %b want 1", o_v); end
    vec(0, 1, 0, 0, 2'b00, 3'b000, 6, 32'h9, 32'h0, 32'h0);
    cycle();
    checks++; if (o_v !== 1'b0) begin errors++; $display("FAIL inv_valid got %b want 0", o_v); end
    checks++; if (o_rw !== 1'b0) begin errors++; $display("FAIL inv_rw got %b want 0", o_rw); end
  endtask

  task automatic test_stall_flush();
    vec(1, 1, 0, 0, 2'b00, 3'b000, 7, 32'h55, 32'h0, 32'h0);
    cycle();
    checks++; if (o_wd !== 32'h55) begin errors++; $display("FAIL pre_stall_wd got %h want 55", o_wd); end
    vec(1, 1, 1, 0, 2'b01, 3'b001, 9, 32'h21, 32'h0, 32'h99);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (o_rd !== 5'd7) begin errors++; $display("FAIL stall_rd[%0d] got %0d want 7", i, o_rd); end
      checks++; if (o_wd !== 32'h55) begin errors++; $display("FAIL stall_wd[%0d] got %h want 55", i, o_wd); end
      checks++; if (o_v !== 1'b1 || o_rw !== 1'b1) begin errors++; $display("FAIL stall_ctl[%0d] got v=%b rw=%b want 1 1", i, o_v, o_rw); end
      checks++; if (o_exc !== 1'b0) begin errors++; $display("FAIL stall_exc[%0d] got %b want 0", i, o_exc); end
    end
    flush = 1;
    cycle();
    checks++; if (o_v !== 1'b0 || o_rw !== 1'b0) begin errors++; $display("FAIL flush_ctl got v=%b rw=%b want 0 0", o_v, o_rw); end
    checks++; if (o_rd !== 5'd0 || o_wd !== 32'h0) begin errors++; $display("FAIL flush_data got rd=%0d wd=%h want 0 0", o_rd, o_wd); end
    checks++; if (o_exc !== 1'b0) begin errors++; $display("FAIL flush_exc got %b want 0", o_exc); end
    idle();
  endtask

  task automatic test_misalign();
    vec(1, 1, 1, 0, 2'b01, 3'b001, 3, 32'h21, 32'h0, 32'h1234);
    cycle();
    checks++; if (o_exc !== 1'b1) begin errors++; $display("FAIL lh_exc got %b want 1", o_exc); end
    checks++; if (o_addr !== 32'h21) begin errors++; $display("FAIL lh_addr got %h want 21", o_addr); end
    checks++; if (o_rw !== 1'b0 || o_v !== 1'b1) begin errors++; $display("FAIL lh_ctl got rw=%b v=%b want 0 1", o_rw, o_v); end
    vec(1, 0, 0, 1, 2'b00, 3'b010, 0, 32'h32, 32'h0, 32'h0);
    cycle();
    checks++; if (o_addr !== 32'h21) begin errors++; $display("FAIL sw_keep_addr got %h want 21", o_addr); end
    vec(1, 1, 1, 0, 2'b01, 3'b010, 8, 32'h43, 32'h0, 32'h0);
    exc_clr = 1;
    cycle();
    checks++; if (o_exc !== 1'b1) begin errors++; $display("FAIL setclr_exc got %b want 1", o_exc); end
    checks++; if (o_addr !== 32'h43) begin errors++; $display("FAIL setclr_addr got %h want 43", o_addr); end
    idle();
    exc_clr = 1;
    cycle();
    checks++; if (o_exc !== 1'b0 || o_addr !== 32'h0) begin errors++; $display("FAIL clr got exc=%b addr=%h want 0 0", o_exc, o_addr); end
    vec(1, 1, 1, 0, 2'b01, 3'b011, 8, 32'h40, 32'h0, 32'h0);
    cycle();
    checks++; if (o_exc !== 1'b1 || o_addr !== 32'h40) begin errors++; $display("FAIL illegal_f3 got exc=%b addr=%h want 1 40", o_exc, o_addr); end
    checks++; if (o_rw !== 1'b0) begin errors++; $display("FAIL illegal_f3_rw got %b want 0", o_rw); end
    idle();
    exc_clr = 1;
    cycle();
    vec(1, 1, 1, 0, 2'b01, 3'b000, 6, 32'h43, 32'h0, 32'h11);
    cycle();
    checks++; if (o_exc !== 1'b0 || o_rw !== 1'b1) begin errors++; $display("FAIL lb_odd got exc=%b rw=%b want 0 1", o_exc, o_rw); end
    checks++; if (o_wd !== 32'h11) begin errors++; $display("FAIL lb_wd got %h want 11", o_wd); end
    vec(1, 1, 1, 0, 2'b01, 3'b101, 6, 32'h22, 32'h0, 32'h22);
    cycle();
    checks++; if (o_exc !== 1'b0 || o_rw !== 1'b1) begin errors++; $display("FAIL lhu_al got exc=%b rw=%b want 0 1", o_exc, o_rw); end
    idle();
  endtask

  task automatic test_async_reset();
    vec(1, 1, 0, 0, 2'b00, 3'b000, 3, 32'hAB, 32'h0, 32'h0);
    cycle();
    checks++; if (o_v !== 1'b1 || o_rd !== 5'd3) begin errors++; $display("FAIL ar_pre got v=%b rd=%0d want 1 3", o_v, o_rd); end
    #3 rst_n = 0;
    #1;
    checks++; if (o_v !== 1'b0 || o_rw !== 1'b0 || o_rd !== 5'd0 || o_wd !== 32'h0) begin errors++; $display("FAIL ar_now got v=%b rw=%b rd=%0d wd=%h want 0", o_v, o_rw, o_rd, o_wd); end
    cycle();
    checks++; if (o_v !== 1'b0 || o_wd !== 32'h0) begin errors++; $display("FAIL ar_hold got v=%b wd=%h want 0 0", o_v, o_wd); end
    #3 rst_n = 1;
    #1;
    checks++; if (o_v !== 1'b0 || o_cnt !== 32'h0) begin errors++; $display("FAIL ar_rel got v=%b cnt=%0d want 0 0", o_v, o_cnt); end
    cycle();
    checks++; if (o_v !== 1'b1 || o_wd !== 32'hAB) begin errors++; $display("FAIL ar_cap got v=%b wd=%h want 1 ab", o_v, o_wd); end
    idle();
  endtask

`ifdef MEM_WB_RETIRE_CNT_EN
  task automatic test_retire_cnt();
    idle();
    #3 rst_n = 0;
    #1 rst_n = 1;
    checks++; if (o_cnt !== 32'd0) begin errors++; $display("FAIL cnt_rst got %0d want 0", o_cnt); end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) vec(1, 1, 1, 0, 2'b01, 3'b001, 3, 32'h21, 32'h0, 32'h0);
      else vec(1, 1, 0, 0, 2'b00, 3'b000, 5'(i + 1), 32'(i), 32'h0, 32'h0);
      cycle();
    end
    stall = 1;
    repeat (2) cycle();
    stall = 0; flush = 1;
    cycle();
    flush = 0; v = 0;
    cycle();
    checks++; if (o_cnt !== 32'd5) begin errors++; $display("FAIL cnt5 got %0d want 5", o_cnt); end
    checks++; if (s_cnt !== 4'd5) begin errors++; $display("FAIL cnt5_w4 got %0d want 5", s_cnt); end
    v = 1;
    repeat (12) cycle();
    checks++; if (o_cnt !== 32'd17) begin errors++; $display("FAIL cnt17 got %0d want 17", o_cnt); end
    checks++; if (s_cnt !== 4'd1) begin errors++; $display("FAIL cnt_wrap got %0d want 1", s_cnt); end
    idle();
    exc_clr = 1;
    cycle();
    idle();
  endtask
`else
  task automatic test_retire_off();
    vec(1, 1, 0, 0, 2'b00, 3'b000, 2, 32'h1, 32'h0, 32'h0);
    repeat (3) cycle();
    checks++; if (o_cnt !== 32'd0) begin errors++; $display("FAIL cnt_off got %0d want 0", o_cnt); end
    idle();
  endtask
`endif

  initial begin
    idle();
    rst_n = 0;
    test_reset();
    test_load();
    test_alu_jal();
    test_stall_flush();
    test_misalign();
    test_async_reset();
`ifdef MEM_WB_RETIRE_CNT_EN
    test_retire_cnt();
`else
    test_retire_off();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
